// File: rtl/quad_encoder_ctr_if.sv
// quad_encoder_ctr_if: encoder inputs, control strobes and position/velocity
// outputs of one motor channel. The master drives the encoder lines and
// control strobes; the slave (quad_encoder_ctr) drives the results.
interface quad_encoder_ctr_if #(
    parameter int CNT_W = 32,
    parameter int VEL_W = 16
);
    logic                    ch_a;
    logic                    ch_b;
    logic                    ch_i;
    logic                    count_clr;
    logic                    err_clr;
    logic signed [CNT_W-1:0] count;
    logic                    dir;
    logic signed [VEL_W-1:0] velocity;
    logic                    vel_valid;
    logic                    err;
    logic                    index_seen;

    modport master (
        output ch_a, ch_b, ch_i, count_clr, err_clr,
        input  count, dir, velocity, vel_valid, err, index_seen
    );

    modport slave (
        input  ch_a, ch_b, ch_i, count_clr, err_clr,
        output count, dir, velocity, vel_valid, err, index_seen
    );
endinterface

// File: rtl/quad_encoder_ctr.sv
// quad_encoder_ctr: synchronised, glitch-filtered x4 quadrature decoder with a
// wrapping signed position count, a saturating per-window velocity measure and
// a sticky illegal-transition flag.
// Optional feature macro: QENC_INDEX_CLEAR_EN (index pulse at AB=11 zeroes count).
module quad_encoder_ctr #(
    parameter int CNT_W      = 32,
    parameter int FILT_LEN   = 3,
    parameter int VEL_PERIOD = 50000,
    parameter int VEL_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    quad_encoder_ctr_if.slave  bus
);
    localparam int              WIN_W     = (VEL_PERIOD > 2) ? $clog2(VEL_PERIOD) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);
    localparam logic [3:0]      FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [4:0]      WARM_LOAD = 5'(3 + FILT_LEN);
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};

    typedef enum logic {ST_WARM, ST_RUN} state_t;

    // Channel bit order: [1] = A, [0] = B
    logic [1:0]              w_raw;
    logic [1:0]              r_s1;
    logic [1:0]              r_s2;
    logic [1:0]              r_filt;
    logic [3:0]              r_fcnt [2];
    logic [1:0]              r_prev;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_decode_en;
    logic [4:0]              r_warm;
    logic [1:0]              w_cur_pos;
    logic [1:0]              w_prev_pos;
    logic [1:0]              w_delta;
    logic                    w_fwd;
    logic                    w_rev;
    logic                    w_illegal;
    logic                    w_index_evt;
    logic signed [CNT_W-1:0] r_count;
    logic                    r_dir;
    logic                    r_err;
    logic [WIN_W-1:0]        r_win;
    logic signed [VEL_W-1:0] r_acc;
    logic signed [VEL_W-1:0] w_acc_nxt;
    logic signed [VEL_W-1:0] r_vel;
    logic                    r_vel_valid;

    assign w_raw = {bus.ch_a, bus.ch_b};

    // Two-stage synchroniser for A and B
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-channel stability filter: accept a new level after FILT_LEN differing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) r_fcnt[ch] <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (r_s2[ch] == r_filt[ch]) begin
                    r_fcnt[ch] <= '0;
                end else if (r_fcnt[ch] == FILT_LAST) begin
                    r_filt[ch] <= r_s2[ch];
                    r_fcnt[ch] <= '0;
                end else begin
                    r_fcnt[ch] <= r_fcnt[ch] + 4'd1;
                end
            end
        end
    end

    // Previous filtered AB, tracked in every state so warm-up absorbs the idle level
    always_ff @(posedge clk) begin
        if (reset) r_prev <= '0;
        else       r_prev <= r_filt;
    end

    // Warm-up FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_WARM;
        else       r_state <= w_state_nxt;
    end

    // Warm-up FSM next state and decoder enable
    always_comb begin
        w_state_nxt = r_state;
        w_decode_en = 1'b0;
        case (r_state)
            ST_WARM: if (r_warm == 5'd1) w_state_nxt = ST_RUN;
            ST_RUN:  w_decode_en = 1'b1;
            default: w_state_nxt = ST_WARM;
        endcase
    end

    // Warm-up cycle countdown
    always_ff @(posedge clk) begin
        if (reset)                                  r_warm <= WARM_LOAD;
        else if (r_state == ST_WARM && r_warm != '0) r_warm <= r_warm - 5'd1;
    end

    // Gray position {B, A^B} maps 00,10,11,01 to 0,1,2,3, so the modulo-4
    // difference gives +1 forward, 3 reverse, 2 illegal.
    assign w_cur_pos  = {r_filt[0], r_filt[1] ^ r_filt[0]};
    assign w_prev_pos = {r_prev[0], r_prev[1] ^ r_prev[0]};
    assign w_delta    = w_cur_pos - w_prev_pos;
    assign w_fwd      = w_decode_en && (w_delta == 2'd1);
    assign w_rev      = w_decode_en && (w_delta == 2'd3);
    assign w_illegal  = w_decode_en && (w_delta == 2'd2);

`ifdef QENC_INDEX_CLEAR_EN
    logic [1:0] r_i_sync;
    logic       r_i_prev;
    logic       r_index_seen;

    // Index synchroniser and previous-level register for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_sync <= '0;
            r_i_prev <= 1'b0;
        end else begin
            r_i_sync <= {r_i_sync[0], bus.ch_i};
            r_i_prev <= r_i_sync[1];
        end
    end

    assign w_index_evt = r_i_sync[1] & ~r_i_prev & r_filt[1] & r_filt[0];

    // Sticky record that an index clear has happened
    always_ff @(posedge clk) begin
        if (reset)            r_index_seen <= 1'b0;
        else if (w_index_evt) r_index_seen <= 1'b1;
    end

    assign bus.index_seen = r_index_seen;
`else
    assign w_index_evt    = 1'b0;
    assign bus.index_seen = 1'b0;
`endif

    // Position count and direction; clear sources discard the concurrent step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_dir   <= 1'b0;
        end else if (bus.count_clr || w_index_evt) begin
            r_count <= '0;
        end else if (w_fwd) begin
            r_count <= r_count + CNT_W'(1);
            r_dir   <= 1'b1;
        end else if (w_rev) begin
            r_count <= r_count - CNT_W'(1);
            r_dir   <= 1'b0;
        end
    end

    // Sticky illegal-transition flag; a new illegal step beats err_clr
    always_ff @(posedge clk) begin
        if (reset)            r_err <= 1'b0;
        else if (w_illegal)   r_err <= 1'b1;
        else if (bus.err_clr) r_err <= 1'b0;
    end

    // Saturating accumulator update including this cycle's step
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_fwd && r_acc != VEL_MAX)      w_acc_nxt = r_acc + VEL_W'(1);
        else if (w_rev && r_acc != VEL_MIN) w_acc_nxt = r_acc - VEL_W'(1);
    end

    // Velocity window: publish the accumulator and restart at window end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_vel       <= '0;
            r_vel_valid <= 1'b0;
        end else if (r_win == WIN_LAST) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_vel       <= w_acc_nxt;
            r_vel_valid <= 1'b1;
        end else begin
            r_win       <= r_win + WIN_W'(1);
            r_acc       <= w_acc_nxt;
            r_vel_valid <= 1'b0;
        end
    end

    assign bus.count     = r_count;
    assign bus.dir       = r_dir;
    assign bus.err       = r_err;
    assign bus.velocity  = r_vel;
    assign bus.vel_valid = r_vel_valid;
endmodule

// File: tb/tb_quad_encoder_ctr.sv
// Testbench for quad_encoder_ctr: directed steps, expected values queued at
// drive time and compared when the DUT result is due.
`timescale 1ns/1ps
module tb_quad_encoder_ctr;
    localparam int CNT_W      = 8;
    localparam int FILT_LEN   = 3;
    localparam int VEL_PERIOD = 100;
    localparam int VEL_W      = 16;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    exp_t       sb [$];
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    quad_encoder_ctr_if #(.CNT_W(CNT_W), .VEL_W(VEL_W)) bus ();

    quad_encoder_ctr #(
        .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_PERIOD(VEL_PERIOD), .VEL_W(VEL_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h, no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit fwd);
        case (ab)
            2'b00:   return fwd ? 2'b10 : 2'b01;
            2'b10:   return fwd ? 2'b11 : 2'b00;
            2'b11:   return fwd ? 2'b01 : 2'b10;
            default: return fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] ab);
        bus.ch_a = ab[1];
        bus.ch_b = ab[0];
    endtask

    task automatic step(input bit fwd);
        drive_ab(next_ab({bus.ch_a, bus.ch_b}, fwd));
        exp_cnt = fwd ? exp_cnt + 8'd1 : exp_cnt - 8'd1;
        push("step_count", {24'd0, exp_cnt});
        push("step_dir", {31'd0, fwd});
        tick(10);
        check_pop({24'd0, bus.count});
        check_pop({31'd0, bus.dir});
    endtask

    task automatic do_reset(input logic a, input logic b);
        reset = 1'b1;
        bus.ch_a = a;
        bus.ch_b = b;
        bus.ch_i = 1'b0;
        bus.count_clr = 1'b0;
        bus.err_clr = 1'b0;
        tick(3);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with A=B=1 idle, then warm-up must absorb the 11 level
        reset = 1'b1;
        bus.ch_a = 1'b1;
        bus.ch_b = 1'b1;
        bus.ch_i = 1'b0;
        bus.count_clr = 1'b0;
        bus.err_clr = 1'b0;
        tick(3);
        push("rst_count", 32'd0);      check_pop({24'd0, bus.count});
        push("rst_dir", 32'd0);        check_pop({31'd0, bus.dir});
        push("rst_velocity", 32'd0);   check_pop({16'd0, bus.velocity});
        push("rst_vel_valid", 32'd0);  check_pop({31'd0, bus.vel_valid});
        push("rst_err", 32'd0);        check_pop({31'd0, bus.err});
        push("rst_index_seen", 32'd0); check_pop({31'd0, bus.index_seen});
        reset = 1'b0;
        tick(10);
        push("warm_count", 32'd0);     check_pop({24'd0, bus.count});
        push("warm_err", 32'd0);       check_pop({31'd0, bus.err});

        // Input-to-count latency of 3+FILT_LEN edges on the first forward step
        do_reset(1'b0, 1'b0);
        tick(10);
        drive_ab(2'b10);
        exp_cnt = 8'd1;
        push("latency_before", 32'd0);
        tick(5);
        check_pop({24'd0, bus.count});
        push("latency_at", 32'd1);
        tick(1);
        check_pop({24'd0, bus.count});
        tick(4);

        // Forward to 8, then reverse to 5
        for (int i = 0; i < 7; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);

        // Glitch rejection on A (AB=10 idle): 2-cycle pulse ignored, 3-cycle accepted
        bus.ch_a = 1'b0;
        tick(2);
        bus.ch_a = 1'b1;
        push("glitch2_count", {24'd0, exp_cnt});
        tick(12);
        check_pop({24'd0, bus.count});
        bus.ch_a = 1'b0;
        tick(3);
        bus.ch_a = 1'b1;
        push("glitch3_step", {24'd0, exp_cnt - 8'd1});
        tick(3);
        check_pop({24'd0, bus.count});
        push("glitch3_return", {24'd0, exp_cnt});
        tick(6);
        check_pop({24'd0, bus.count});

        // Illegal 10 -> 01, then clear the sticky flag
        drive_ab(2'b01);
        push("illegal_err", 32'd1);
        push("illegal_count", {24'd0, exp_cnt});
        tick(10);
        check_pop({31'd0, bus.err});
        check_pop({24'd0, bus.count});
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        push("err_clr", 32'd0);
        check_pop({31'd0, bus.err});

        // Clear, climb to 127, wrap to -128
        bus.count_clr = 1'b1;
        tick(1);
        bus.count_clr = 1'b0;
        exp_cnt = '0;
        push("count_clr", 32'd0);
        check_pop({24'd0, bus.count});
        for (int i = 0; i < 127; i++) step(1'b1);
        step(1'b1);
        push("wrap_signed", 32'hFFFF_FF80);
        check_pop(32'($signed(bus.count)));

        // count_clr on exactly the edge that would apply a step
        drive_ab(next_ab({bus.ch_a, bus.ch_b}, 1'b1));
        push("clr_step_before", {24'd0, exp_cnt});
        tick(5);
        check_pop({24'd0, bus.count});
        bus.count_clr = 1'b1;
        tick(1);
        bus.count_clr = 1'b0;
        exp_cnt = '0;
        push("clr_step_edge", 32'd0);
        check_pop({24'd0, bus.count});
        push("clr_step_after", 32'd0);
        tick(6);
        check_pop({24'd0, bus.count});

        // Velocity: 5 forward steps inside the first window after reset
        do_reset(1'b0, 1'b0);
        tick(10);
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 200 && !bus.vel_valid; i++) tick(1);
        push("vel_valid_seen", 32'd1);  check_pop({31'd0, bus.vel_valid});
        push("vel_cycle", 32'd100);     check_pop(32'(cyc));
        push("velocity", 32'd5);        check_pop({16'd0, bus.velocity});
        tick(1);
        push("vel_valid_pulse", 32'd0); check_pop({31'd0, bus.vel_valid});
        tick(99);
        push("vel2_valid", 32'd1);      check_pop({31'd0, bus.vel_valid});
        push("vel2_value", 32'd0);      check_pop({16'd0, bus.velocity});

`ifdef QENC_INDEX_CLEAR_EN
        // Index rise at AB=11 zeroes count and sets index_seen
        step(1'b1);
        bus.ch_i = 1'b1;
        exp_cnt = '0;
        push("index_count", 32'd0);
        push("index_seen", 32'd1);
        tick(6);
        check_pop({24'd0, bus.count});
        check_pop({31'd0, bus.index_seen});
`else
        // Index ignored when the feature is not built
        step(1'b1);
        bus.ch_i = 1'b1;
        push("index_ignored_count", {24'd0, exp_cnt});
        push("index_seen_tied", 32'd0);
        tick(6);
        check_pop({24'd0, bus.count});
        check_pop({31'd0, bus.index_seen});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quad_encoder_ctr.md
# quad_encoder_ctr

Parametrised quadrature encoder interface for the motor-control datapath. It synchronises and glitch-filters the A/B channels, decodes x4 quadrature steps into a signed wrapping position count, and measures velocity as signed steps per fixed sample window. It also flags illegal transitions and can optionally zero the count on the index pulse. Each motor channel gets one instance; outputs feed the PID/register bank.

## Interface
- CNT_W, 32: position counter width (signed, two's complement)
- FILT_LEN, 3: consecutive stable cycles required before a channel change is accepted (1..15)
- VEL_PERIOD, 50000: velocity window length in clk cycles (≥2)
- VEL_W, 16: velocity output width (signed, saturating)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ch_a  in  1  encoder channel A (asynchronous)
- ch_b  in  1  encoder channel B (asynchronous)
- ch_i  in  1  index channel (asynchronous); used only with QENC_INDEX_CLEAR_EN
- count_clr  in  1  synchronous clear of count
- err_clr  in  1  clears sticky err
- count  out  CNT_W  signed position
- dir  out  1  direction of last accepted step (1 = forward)
- velocity  out  VEL_W  signed steps counted in last completed window
- vel_valid  out  1  one-cycle strobe when velocity updates
- err  out  1  sticky illegal-transition flag
- index_seen  out  1  sticky; index clear has occurred

## Operation
- Reset values: count=0, dir=0, velocity=0, vel_valid=0, err=0, index_seen=0; sync/filter registers=0; window counter=0; warm-up counter loaded.
- Sync: 2-FF synchroniser per input (A, B, I).
- Filter (A and B independently): counter increments while synced≠filtered and clears when equal; once synced≠filtered for FILT_LEN consecutive cycles, filtered takes the synced value.
- Decode: compare filtered AB with previous AB. Forward sequence 00→10→11→01→00 is +1 and sets dir=1. Reverse is −1 and sets dir=0. No change is no-op.
- Illegal (both bits change in one cycle): no count, dir held, err set. err_clr clears err; a set on the same cycle wins.
- Warm-up: for 3+FILT_LEN cycles after reset deasserts, the decoder only tracks previous AB and produces no step and no err. This absorbs a non-zero idle state.
- count: ±1 per step, wraps modulo 2^CNT_W. count_clr forces 0 and discards that cycle's step.
- Velocity: signed accumulator over VEL_PERIOD cycles, saturating at ±(2^(VEL_W−1)−1). At window end, velocity = accumulator including that cycle's step, vel_valid=1 for one cycle, and the accumulator restarts at 0. count_clr does not affect velocity.

## Timing
- Input edge to count update: the count reflects an input change (stable, set up before edge 1) at rising edge 3+FILT_LEN; 6 for the default.
- Glitches shorter than FILT_LEN synced cycles are rejected entirely.
- Maximum step rate is one per FILT_LEN+1 cycles per channel; faster input is undefined.
- vel_valid fires on cycles VEL_PERIOD, 2·VEL_PERIOD, … after reset release.
- Reset mid-operation: all state returns to reset values on the next edge, and a new warm-up begins.

## Configuration
- QENC_INDEX_CLEAR_EN defined: a rising edge of synced ch_i while filtered A=1 and B=1 zeroes count and sets index_seen. Priority: count_clr and index both give 0. The step on that cycle is discarded. index_seen clears only on reset.
- Not defined: ch_i is ignored (synchroniser removed) and index_seen is tied to 0.

## Test plan
- Reset with A=B=1 held, wait 10 cycles → count=0, err=0 (warm-up absorbs 11).
- 8 forward steps (AB 00→10→11→01→00 ×2, 10 cycles per step) → count=8, dir=1; then 3 reverse steps → count=5, dir=0.
- 2-cycle pulse on A with FILT_LEN=3 → count unchanged; 3-cycle pulse → one step accepted.
- Filtered AB 00→11 in one cycle → err=1, count unchanged; assert err_clr → err=0.
- CNT_W=8: preload to 127 via 127 forward steps, then one more step → count=−128; count_clr concurrent with a step → 0.
- VEL_PERIOD=100: 5 forward steps within a window → velocity=5 with a one-cycle vel_valid at cycle 100. With macro defined: ch_i rise at AB=11 → count=0, index_seen=1.
